// File: rtl/pmesh_translator_utlb_pkg.sv
// Shared types and helpers for the PMESH VPN->PPN translator with micro-TLB.
package pmesh_translator_utlb_pkg;

    localparam int DEF_PADDR_W       = 40;
    localparam int DEF_PAGE_OFFSET_W = 12;
    localparam int DEF_PN_W          = DEF_PADDR_W - DEF_PAGE_OFFSET_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_QUERY = 2'd1,
        S_REQ   = 2'd2
    } state_t;

    typedef logic [DEF_PN_W-1:0] pn_t;

    typedef struct packed {
        logic valid;
        pn_t  vpn;
        pn_t  ppn;
    } utlb_entry_t;

    // Index width of the replacement pointer; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pmesh_translator_utlb_if.sv
// Request-in, translated-request-out and shared-TLB query bundle for the translator.
interface pmesh_translator_utlb_if #(
    parameter int PADDR_W       = 40,
    parameter int PAGE_OFFSET_W = 12,
    parameter int PAYLOAD_W     = 256
);
    localparam int PN_W = PADDR_W - PAGE_OFFSET_W;

    logic                 in_valid;
    logic                 in_ready;
    logic [PADDR_W-1:0]   in_addr;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 out_valid;
    logic                 out_ready;
    logic [PADDR_W-1:0]   out_addr;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 tlb_valid;
    logic [PN_W-1:0]      tlb_vpn;
    logic                 tlb_ack;
    logic [PN_W-1:0]      tlb_ppn;
    logic                 flush;

    // Translator side.
    modport slave (
        input  in_valid, in_addr, in_payload, out_ready, tlb_ack, tlb_ppn, flush,
        output in_ready, out_valid, out_addr, out_payload, tlb_valid, tlb_vpn
    );

    // Requester / downstream / TLB side.
    modport master (
        output in_valid, in_addr, in_payload, out_ready, tlb_ack, tlb_ppn, flush,
        input  in_ready, out_valid, out_addr, out_payload, tlb_valid, tlb_vpn
    );

endinterface

// File: rtl/pmesh_translator_utlb_cam.sv
// Fully-associative micro-TLB: parallel VPN match, round-robin fill, bulk flush.
module pmesh_translator_utlb_cam
    import pmesh_translator_utlb_pkg::*;
#(
    parameter int PN_W        = 28,
    parameter int NUM_ENTRIES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PN_W-1:0] lookup_vpn,
    output logic            hit,
    output logic [PN_W-1:0] hit_ppn,
    input  logic            fill_en,
    input  logic [PN_W-1:0] fill_vpn,
    input  logic [PN_W-1:0] fill_ppn,
    input  logic            flush
);
    localparam int IDX_W = idx_width(NUM_ENTRIES);

    logic [NUM_ENTRIES-1:0]      match;
    logic [NUM_ENTRIES*PN_W-1:0] ppn_flat;
    logic [IDX_W-1:0]            ptr_reg;
    logic                        multi_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
            logic            valid_reg;
            logic [PN_W-1:0] vpn_reg;
            logic [PN_W-1:0] ppn_reg;

            // Flush beats a coincident fill: the entry stays invalid.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    vpn_reg   <= '0;
                    ppn_reg   <= '0;
                end else if (flush) begin
                    valid_reg <= 1'b0;
                end else if (fill_en && (ptr_reg == IDX_W'(gi))) begin
                    valid_reg <= 1'b1;
                    vpn_reg   <= fill_vpn;
                    ppn_reg   <= fill_ppn;
                end
            end

            assign match[gi] = valid_reg && (vpn_reg == lookup_vpn);
            assign ppn_flat[gi*PN_W +: PN_W] = match[gi] ? ppn_reg : '0;
        end
    endgenerate

    always_comb begin
        hit_ppn = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            hit_ppn = hit_ppn | ppn_flat[i*PN_W +: PN_W];
        end
    end

    assign hit       = |match;
    assign multi_hit = (match & (match - NUM_ENTRIES'(1))) != '0;

    // Pointer advances on every fill, even one cancelled by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (fill_en) begin
            ptr_reg <= (ptr_reg == IDX_W'(NUM_ENTRIES - 1)) ? '0 : ptr_reg + IDX_W'(1);
        end
    end

    a_unique_vpn: assert property (@(posedge clk) disable iff (rst) !multi_hit);

endmodule

// File: rtl/pmesh_translator_utlb.sv
// PMESH VPN->PPN translator with a fully-associative micro-TLB ahead of the shared TLB port.
// Optional hit/miss counters are built when PMESH_TRANSLATOR_UTLB_PERF_EN is defined.
module pmesh_translator_utlb
    import pmesh_translator_utlb_pkg::*;
#(
    parameter int PADDR_W       = 40,
    parameter int PAGE_OFFSET_W = 12,
    parameter int NUM_ENTRIES   = 4,
    parameter int PAYLOAD_W     = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    pmesh_translator_utlb_if.slave   bus
`ifdef PMESH_TRANSLATOR_UTLB_PERF_EN
    ,
    output logic [31:0]              perf_hits,
    output logic [31:0]              perf_misses
`endif
);
    localparam int PN_W = PADDR_W - PAGE_OFFSET_W;

    state_t                   state_reg;
    logic                     in_ready_reg;
    logic                     out_valid_reg;
    logic                     tlb_valid_reg;
    logic [PN_W-1:0]          vpn_reg;
    logic [PAGE_OFFSET_W-1:0] offset_reg;
    logic [PAYLOAD_W-1:0]     payload_reg;
    logic [PN_W-1:0]          ppn_reg;

    logic                     accept;
    logic [PN_W-1:0]          lookup_vpn;
    logic                     cam_hit;
    logic [PN_W-1:0]          cam_hit_ppn;
    logic                     fill_en;

    assign lookup_vpn = bus.in_addr[PADDR_W-1:PAGE_OFFSET_W];
    assign accept     = bus.in_valid && in_ready_reg;
    assign fill_en    = (state_reg == S_QUERY) && bus.tlb_ack;

    pmesh_translator_utlb_cam #(
        .PN_W        (PN_W),
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_cam (
        .clk        (clk),
        .rst        (rst),
        .lookup_vpn (lookup_vpn),
        .hit        (cam_hit),
        .hit_ppn    (cam_hit_ppn),
        .fill_en    (fill_en),
        .fill_vpn   (vpn_reg),
        .fill_ppn   (bus.tlb_ppn),
        .flush      (bus.flush)
    );

    // in_ready mirrors "state is IDLE" but stays low through reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            tlb_valid_reg <= 1'b0;
            vpn_reg       <= '0;
            offset_reg    <= '0;
            payload_reg   <= '0;
            ppn_reg       <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        vpn_reg      <= lookup_vpn;
                        offset_reg   <= bus.in_addr[PAGE_OFFSET_W-1:0];
                        payload_reg  <= bus.in_payload;
                        in_ready_reg <= 1'b0;
                        if (cam_hit) begin
                            ppn_reg       <= cam_hit_ppn;
                            out_valid_reg <= 1'b1;
                            state_reg     <= S_REQ;
                        end else begin
                            tlb_valid_reg <= 1'b1;
                            state_reg     <= S_QUERY;
                        end
                    end else begin
                        in_ready_reg <= 1'b1;
                    end
                end
                S_QUERY: begin
                    if (bus.tlb_ack) begin
                        ppn_reg       <= bus.tlb_ppn;
                        tlb_valid_reg <= 1'b0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= S_IDLE;
                    end
                end
                default: begin
                    state_reg     <= S_IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    tlb_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_reg;
    assign bus.out_valid   = out_valid_reg;
    assign bus.out_addr    = {ppn_reg, offset_reg};
    assign bus.out_payload = payload_reg;
    assign bus.tlb_valid   = tlb_valid_reg;
    assign bus.tlb_vpn     = vpn_reg;

`ifdef PMESH_TRANSLATOR_UTLB_PERF_EN
    logic [31:0] perf_hits_reg;
    logic [31:0] perf_misses_reg;

    // Saturating counters; deliberately untouched by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_hits_reg   <= '0;
            perf_misses_reg <= '0;
        end else if (accept && (state_reg == S_IDLE)) begin
            if (cam_hit) begin
                if (perf_hits_reg != '1) perf_hits_reg <= perf_hits_reg + 32'd1;
            end else begin
                if (perf_misses_reg != '1) perf_misses_reg <= perf_misses_reg + 32'd1;
            end
        end
    end

    assign perf_hits   = perf_hits_reg;
    assign perf_misses = perf_misses_reg;
`endif

endmodule

// File: tb/tb_pmesh_translator_utlb.sv
// Scoreboard bench for pmesh_translator_utlb: directed requests, queued expectations, output monitor.
module tb_pmesh_translator_utlb;

    localparam int PADDR_W       = 40;
    localparam int PAGE_OFFSET_W = 12;
    localparam int NUM_ENTRIES   = 4;
    localparam int PAYLOAD_W     = 256;
    localparam int PN_W          = PADDR_W - PAGE_OFFSET_W;

    typedef struct packed {
        logic [PADDR_W-1:0]   addr;
        logic [PAYLOAD_W-1:0] payload;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    pmesh_translator_utlb_if #(
        .PADDR_W       (PADDR_W),
        .PAGE_OFFSET_W (PAGE_OFFSET_W),
        .PAYLOAD_W     (PAYLOAD_W)
    ) bus_if ();

`ifdef PMESH_TRANSLATOR_UTLB_PERF_EN
    logic [31:0] perf_hits;
    logic [31:0] perf_misses;
`endif

    pmesh_translator_utlb #(
        .PADDR_W       (PADDR_W),
        .PAGE_OFFSET_W (PAGE_OFFSET_W),
        .NUM_ENTRIES   (NUM_ENTRIES),
        .PAYLOAD_W     (PAYLOAD_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if.slave)
`ifdef PMESH_TRANSLATOR_UTLB_PERF_EN
        ,
        .perf_hits   (perf_hits),
        .perf_misses (perf_misses)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [PAYLOAD_W-1:0] act,
                         input logic [PAYLOAD_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: pops one expectation per out_valid & out_ready handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus_if.out_valid && bus_if.out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got addr %0h required no output", bus_if.out_addr);
            end else begin
                e = exp_q.pop_front();
                check("out_addr", PAYLOAD_W'(bus_if.out_addr), PAYLOAD_W'(e.addr));
                check("out_payload", bus_if.out_payload, e.payload);
                $display("[TB] out addr=%h payload[31:0]=%h", bus_if.out_addr, bus_if.out_payload[31:0]);
            end
        end
    end

    // One request end to end; exp_hit decides whether a TLB query must appear.
    task automatic send(input logic [PN_W-1:0] vpn, input logic [PAGE_OFFSET_W-1:0] off,
                        input logic [PAYLOAD_W-1:0] pl, input bit exp_hit,
                        input logic [PN_W-1:0] ppn, input int ack_delay,
                        input int hold, input bit flush_on_ack);
        int waited = 0;
        bus_if.out_ready = (hold == 0);
        while (!bus_if.in_ready && waited < 20) begin
            cycle();
            waited++;
        end
        check("in_ready_wait", PAYLOAD_W'(bus_if.in_ready), 1);
        bus_if.in_valid   = 1'b1;
        bus_if.in_addr    = {vpn, off};
        bus_if.in_payload = pl;
        exp_q.push_back('{addr: {ppn, off}, payload: pl});
        cycle();
        bus_if.in_valid = 1'b0;
        check("accept_drops_ready", PAYLOAD_W'(bus_if.in_ready), 0);
        if (exp_hit) begin
            check("hit_no_query", PAYLOAD_W'(bus_if.tlb_valid), 0);
            check("hit_latency", PAYLOAD_W'(bus_if.out_valid), 1);
        end else begin
            check("miss_no_out", PAYLOAD_W'(bus_if.out_valid), 0);
            for (int i = 0; i < ack_delay; i++) begin
                check("tlb_valid_held", PAYLOAD_W'(bus_if.tlb_valid), 1);
                check("tlb_vpn_held", PAYLOAD_W'(bus_if.tlb_vpn), PAYLOAD_W'(vpn));
                cycle();
            end
            check("tlb_valid_at_ack", PAYLOAD_W'(bus_if.tlb_valid), 1);
            bus_if.tlb_ack = 1'b1;
            bus_if.tlb_ppn = ppn;
            bus_if.flush   = flush_on_ack;
            cycle();
            bus_if.tlb_ack = 1'b0;
            bus_if.tlb_ppn = '0;
            bus_if.flush   = 1'b0;
            check("miss_latency", PAYLOAD_W'(bus_if.out_valid), 1);
            check("tlb_valid_drop", PAYLOAD_W'(bus_if.tlb_valid), 0);
        end
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                cycle();
                check("bp_out_valid", PAYLOAD_W'(bus_if.out_valid), 1);
                check("bp_out_addr", PAYLOAD_W'(bus_if.out_addr), PAYLOAD_W'({ppn, off}));
                check("bp_out_payload", bus_if.out_payload, pl);
                check("bp_in_ready", PAYLOAD_W'(bus_if.in_ready), 0);
            end
            bus_if.out_ready = 1'b1;
        end
        cycle();
        check("out_valid_drop", PAYLOAD_W'(bus_if.out_valid), 0);
        check("in_ready_next", PAYLOAD_W'(bus_if.in_ready), 1);
    endtask

    function automatic logic [PAYLOAD_W-1:0] mk_pl(input logic [31:0] tag);
        return {8{tag}};
    endfunction

    initial begin
        logic [PN_W-1:0] wrap_vpn [5];
        wrap_vpn = '{28'h1, 28'h2, 28'h3, 28'h4, 28'h5};

        rst               = 1'b1;
        bus_if.in_valid   = 1'b0;
        bus_if.in_addr    = '0;
        bus_if.in_payload = '0;
        bus_if.out_ready  = 1'b1;
        bus_if.tlb_ack    = 1'b0;
        bus_if.tlb_ppn    = '0;
        bus_if.flush      = 1'b0;
        repeat (2) cycle();
        check("rst_in_ready", PAYLOAD_W'(bus_if.in_ready), 0);
        check("rst_out_valid", PAYLOAD_W'(bus_if.out_valid), 0);
        check("rst_tlb_valid", PAYLOAD_W'(bus_if.tlb_valid), 0);
        check("rst_out_addr", PAYLOAD_W'(bus_if.out_addr), 0);
        check("rst_out_payload", bus_if.out_payload, 0);
        check("rst_tlb_vpn", PAYLOAD_W'(bus_if.tlb_vpn), 0);
        @(negedge clk);
        rst = 1'b0;
        cycle();
        check("post_rst_in_ready", PAYLOAD_W'(bus_if.in_ready), 1);

        // Cold miss on 0x00_1234_5678 -> 0x00_ABCD_E678, ack after 3 cycles.
        send(28'h0012345, 12'h678, mk_pl(32'hC0DE_0001), 1'b0, 28'h00ABCDE, 3, 0, 1'b0);
        // Same VPN, new offset: micro-TLB hit -> 0x00_ABCD_E010.
        send(28'h0012345, 12'h010, mk_pl(32'hC0DE_0002), 1'b1, 28'h00ABCDE, 0, 0, 1'b0);

        // Five misses through four entries: VPN 5 evicts VPN 1.
        for (int i = 0; i < 5; i++) begin
            send(wrap_vpn[i], 12'h100, mk_pl(32'hC0DE_0010 + i), 1'b0,
                 28'h100 + PN_W'(wrap_vpn[i]), 1, 0, 1'b0);
        end
        send(28'h2, 12'h200, mk_pl(32'hC0DE_0020), 1'b1, 28'h102, 0, 0, 1'b0);
        send(28'h1, 12'h300, mk_pl(32'hC0DE_0021), 1'b0, 28'h201, 2, 0, 1'b0);

        // Backpressure on a hit to VPN 4 (cached as 0x104).
        send(28'h4, 12'hABC, mk_pl(32'hC0DE_0030), 1'b1, 28'h104, 0, 10, 1'b0);

        // Flush coinciding with the fill: returned PPN used, nothing cached.
        send(28'h77, 12'h044, mk_pl(32'hC0DE_0040), 1'b0, 28'h777, 1, 0, 1'b1);
        send(28'h77, 12'h055, mk_pl(32'hC0DE_0041), 1'b0, 28'h778, 1, 0, 1'b0);
        send(28'h3, 12'h066, mk_pl(32'hC0DE_0042), 1'b0, 28'h333, 1, 0, 1'b0);

        // Reset while the TLB query is outstanding.
        bus_if.in_valid = 1'b1;
        bus_if.in_addr  = {28'h99, 12'h000};
        cycle();
        bus_if.in_valid = 1'b0;
        check("abort_query_up", PAYLOAD_W'(bus_if.tlb_valid), 1);
        cycle();
        #1 rst = 1'b1;
        #1;
        check("abort_tlb_valid", PAYLOAD_W'(bus_if.tlb_valid), 0);
        check("abort_out_valid", PAYLOAD_W'(bus_if.out_valid), 0);
        check("abort_in_ready", PAYLOAD_W'(bus_if.in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        cycle();
        send(28'h77, 12'h03C, mk_pl(32'hC0DE_0050), 1'b0, 28'h555, 2, 0, 1'b0);
        send(28'h77, 12'h000, mk_pl(32'hC0DE_0051), 1'b1, 28'h555, 0, 0, 1'b0);

`ifdef PMESH_TRANSLATOR_UTLB_PERF_EN
        check("perf_hits", PAYLOAD_W'(perf_hits), 1);
        check("perf_misses", PAYLOAD_W'(perf_misses), 1);
`endif
        repeat (2) cycle();
        check("scoreboard_drained", PAYLOAD_W'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pmesh_translator_utlb.md
Name: pmesh_translator_utlb

Overview:
- Parametrised successor to the single-request PMESH VPN->PPN load translator.
- Accepts one memory request carrying a virtual address and emits the same request carrying the physical address.
- Adds a fully-associative micro-TLB of NUM_ENTRIES entries, so hits bypass the TLB query.
- Sits between the DCP request generator and the PMESH request path, ahead of the shared TLB port.

Parameters:
- PADDR_W, 40 (`DCP_PADDR): request address width.
- PAGE_OFFSET_W, 12: untranslated page-offset bits. Derived PN_W = PADDR_W - PAGE_OFFSET_W.
- NUM_ENTRIES, 4: micro-TLB entries, >=1. Derived IDX_W = max(1, clog2(NUM_ENTRIES)).
- PAYLOAD_W, 256: packed non-address request fields (req_type, mshrid, size, homeid, write_mask, data_0, data_1), passed through untouched.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  virtual-address request valid
- in_ready  out  1  request accepted
- in_addr  in  PADDR_W  virtual address
- in_payload  in  PAYLOAD_W  pass-through fields
- out_valid  out  1  translated request valid
- out_ready  in  1  downstream accepts
- out_addr  out  PADDR_W  {ppn, page offset}
- out_payload  out  PAYLOAD_W  registered copy of in_payload
- tlb_valid  out  1  TLB query valid
- tlb_vpn  out  PN_W  VPN being queried
- tlb_ack  in  1  TLB response; ppn valid this cycle
- tlb_ppn  in  PN_W  translated PN
- flush  in  1  invalidate all micro-TLB entries (single-cycle pulse or level)

Behaviour:
- Reset (async, rst=1):
  - state S_IDLE; all entry valid bits 0; replacement pointer 0; request registers 0.
  - in_ready=0 while rst is high; out_valid=0; tlb_valid=0; out_addr=0; out_payload=0; tlb_vpn=0.
  - Reset mid-operation abandons the request with no output. The TLB side must tolerate a dropped query.
- Input capture:
  - in_ready = (state == S_IDLE), driven from the registered state only.
  - Handshake in_valid & in_ready captures in_addr and in_payload into holding registers.
  - The input interface is therefore released after one cycle, unlike the previous generation's hold-until-output behaviour.
- Lookup:
  - Combinational in S_IDLE on in_addr[PADDR_W-1:PAGE_OFFSET_W] against all valid entries.
  - Hit: next state S_REQ and the entry's PPN is latched. out_valid rises the cycle after the handshake, giving a hit latency of 1 cycle.
  - Miss: next state S_QUERY.
  - At most one entry may hold a given VPN. A multiple match is an assertion failure.
- S_QUERY:
  - tlb_valid=1 and tlb_vpn = captured VPN, both held stable until tlb_ack.
  - On tlb_ack: latch tlb_ppn, write {vpn, ppn, valid=1} into the entry at the replacement pointer, then move to S_REQ.
  - The replacement pointer increments by 1 per fill and wraps NUM_ENTRIES-1 -> 0. No increment on hits.
  - Miss latency: out_valid rises 1 cycle after tlb_ack.
- S_REQ:
  - out_valid=1; out_addr = {latched ppn, captured offset}; out_payload = captured payload.
  - All three hold stable until out_ready.
  - out_valid & out_ready -> S_IDLE. The next in_ready comes 1 cycle later, so there is no same-cycle re-accept.
- Flush:
  - Clears all valid bits at the next edge. The replacement pointer is not reset.
  - Flush on the same cycle as a fill: flush wins and the entry is not written, but the current request still completes with the returned PPN.
  - Flush on the same cycle as a hit lookup: the lookup uses pre-flush contents.
  - Flush never disturbs an in-flight request or state.
- Unused state encodings go to S_IDLE.

Optional Feature:
- Macro: PMESH_TRANSLATOR_UTLB_PERF_EN.
- Defined:
  - Adds outputs perf_hits and perf_misses, 32 bits each.
  - perf_hits increments on each accepted request that hits; perf_misses on each that misses.
  - Both saturate at 2^32-1, reset to 0, and are not cleared by flush.
- Undefined: neither the ports nor the counters exist, and behaviour is otherwise identical.

Decomposition:
- translator_pkg gains:
  - state_t enum {S_IDLE, S_QUERY, S_REQ};
  - utlb_entry_t struct {valid, vpn, ppn};
  - pn_t, re-used at PN_W.
- One sub-module, translator_utlb_cam: entry storage, parallel match (hit, hit_ppn), fill port, flush, and replacement pointer.

Test Plan:
- Cold miss: in_addr=0x00_1234_5678, tlb_ack after 3 cycles with tlb_ppn=0xABCDE -> tlb_vpn=0x0012345 held; out_addr=0x00_ABCD_E678, payload unchanged; out_valid 1 cycle after ack.
- Hit: repeat the same VPN with offset 0x010 -> tlb_valid stays 0; out_valid on the cycle after the handshake; out_addr=0x00_ABCD_E010.
- Wrap/replacement: with NUM_ENTRIES=4, miss VPNs 1,2,3,4,5 -> VPN 5 evicts VPN 1; re-access of VPN 1 misses and VPN 2 still hits.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid, out_addr and out_payload stay stable; in_ready stays 0; release -> IDLE and in_ready=1 next cycle.
- Flush on the fill cycle: assert flush with tlb_ack -> request completes with the returned PPN; the same VPN afterwards misses.
- Async reset asserted in S_QUERY -> tlb_valid and out_valid drop immediately; after release, a previously cached VPN misses.
